// File: rtl/rr_mux4_if.sv
// rr_mux4_if: bundle of the four merged input streams and the single output stream.
// master = traffic source/sink around the merger, slave = the merger itself.
interface rr_mux4_if #(
  parameter int unsigned WIDTH = 8
);
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_ch;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/rr_mux4.sv
// rr_mux4: merges four valid/ready streams into one registered output stream.
// Arbitration is fixed priority (ch0 highest) by default; define RR_MUX4_RR_EN
// for round-robin starting after the most recently transferred channel.
// in_ready is combinational (depends on out_ready and arbitration).
module rr_mux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_mux4_if.slave   bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             free_c;
  logic             gnt_hit_c;
  logic [1:0]       gnt_idx_c;
  logic             xfer_c;
`ifdef RR_MUX4_RR_EN
  logic [1:0]       last_q, last_d;
`endif

  // Output register can accept a new beat when empty or being drained.
  assign free_c = !out_valid_q || bus.out_ready;

  // Arbitration: pick the winning valid channel.
  always_comb begin
    logic [1:0] cand;
    gnt_hit_c = 1'b0;
    gnt_idx_c = 2'd0;
    cand      = 2'd0;
`ifdef RR_MUX4_RR_EN
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!gnt_hit_c && bus.in_valid[cand]) begin
        gnt_hit_c = 1'b1;
        gnt_idx_c = cand;
      end
    end
`else
    for (int k = 3; k >= 0; k--) begin
      cand = 2'(k);
      if (bus.in_valid[cand]) begin
        gnt_hit_c = 1'b1;
        gnt_idx_c = cand;
      end
    end
`endif
  end

  // Grant only while out of reset and the output register is free.
  assign xfer_c = rst_n && free_c && gnt_hit_c;

  // One-hot accept towards the winning channel.
  always_comb begin
    bus.in_ready = 4'b0000;
    if (xfer_c) begin
      bus.in_ready = 4'(1) << gnt_idx_c;
    end
  end

  // Next-state for the output register and arbitration pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
`ifdef RR_MUX4_RR_EN
    last_d      = last_q;
`endif
    if (free_c) begin
      out_valid_d = xfer_c;
    end
    if (xfer_c) begin
      out_ch_d = gnt_idx_c;
      for (int i = 0; i < 4; i++) begin
        if (gnt_idx_c == 2'(i)) begin
          out_data_d = bus.in_data[i*WIDTH +: WIDTH];
        end
      end
`ifdef RR_MUX4_RR_EN
      last_d = gnt_idx_c;
`endif
    end
  end

  // State registers; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= 2'd0;
`ifdef RR_MUX4_RR_EN
      last_q      <= 2'd3;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
`ifdef RR_MUX4_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux4.sv
// tb_rr_mux4: table-driven directed checks plus hand-written reset, backpressure
// and arbitration sequences for rr_mux4 (WIDTH = 8).
module tb_rr_mux4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  rr_mux4_if #(.WIDTH(8)) bus ();

  rr_mux4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic        ordy;
    logic [31:0] data;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [7:0] od, input logic [1:0] ch);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, ".out_data"},  32'(bus.out_data),  32'(od));
    check({tag, ".out_ch"},    32'(bus.out_ch),    32'(ch));
  endtask

  initial begin
    logic [1:0] exp_ch;
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{4'b0100, 1'b1, 32'h13A5_1110, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1]  = '{4'b0000, 1'b1, 32'h1312_1110, 4'b0000, 1'b0, 8'hA5, 2'd2};
    vecs[2]  = '{4'b0000, 1'b0, 32'h1312_1110, 4'b0000, 1'b0, 8'hA5, 2'd2};
    vecs[3]  = '{4'b1000, 1'b0, 32'h3C12_1110, 4'b1000, 1'b1, 8'h3C, 2'd3};
    vecs[4]  = '{4'b1111, 1'b0, 32'h1312_1110, 4'b0000, 1'b1, 8'h3C, 2'd3};
    vecs[5]  = '{4'b1111, 1'b0, 32'h1312_1110, 4'b0000, 1'b1, 8'h3C, 2'd3};
    vecs[6]  = '{4'b1111, 1'b0, 32'h1312_1110, 4'b0000, 1'b1, 8'h3C, 2'd3};
    vecs[7]  = '{4'b1111, 1'b0, 32'h1312_1110, 4'b0000, 1'b1, 8'h3C, 2'd3};
    vecs[8]  = '{4'b1111, 1'b0, 32'h1312_1110, 4'b0000, 1'b1, 8'h3C, 2'd3};
    vecs[9]  = '{4'b1111, 1'b1, 32'h1312_1110, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[10] = '{4'b0010, 1'b1, 32'h1312_1110, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[11] = '{4'b0000, 1'b1, 32'h1312_1110, 4'b0000, 1'b0, 8'h11, 2'd1};

    // Reset with every channel requesting.
    rst_n        = 1'b0;
    bus.in_valid = 4'b1111;
    bus.in_data  = 32'h1312_1110;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 8'h00, 2'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'h0);

    // Release: first beat comes from channel 0.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first.in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk); #1;
    check_out("first", 1'b1, 8'h10, 2'd0);
    @(negedge clk);
    bus.in_valid = 4'b0000;
    @(posedge clk); #1;
    check_out("drain", 1'b0, 8'h10, 2'd0);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.in_valid  = vecs[i].iv;
      bus.out_ready = vecs[i].ordy;
      bus.in_data   = vecs[i].data;
      #1;
      check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_ch);
    end

    // Reset mid-stream while a beat is held under backpressure.
    @(negedge clk);
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b0;
    bus.in_data   = 32'h1355_1110;
    @(posedge clk); #1;
    check_out("held", 1'b1, 8'h55, 2'd2);
    @(negedge clk);
    bus.in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("midrst", 1'b0, 8'h00, 2'd0);
    check("midrst.in_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    bus.in_valid = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_out("post_rst", 1'b0, 8'h00, 2'd0);

    // All channels requesting, sink always ready.
    @(negedge clk);
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    bus.in_data   = 32'h1312_1110;
    for (int c = 0; c < 5; c++) begin
`ifdef RR_MUX4_RR_EN
      exp_ch = 2'(c);
`else
      exp_ch = 2'd0;
`endif
      #1;
      check($sformatf("arb%0d.in_ready", c), 32'(bus.in_ready), 32'(4'(1) << exp_ch));
      @(posedge clk); #1;
      check_out($sformatf("arb%0d", c), 1'b1, 8'h10 + 8'(exp_ch), exp_ch);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
